// File: rtl/sseg_pkg.sv
// sseg_pkg: shared FSM state type and default parameters for the seven-segment display arbiter
package sseg_pkg;
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam logic [15:0] DEF_IDLE_DATA = 16'h0000;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick (req, start in; onehot, idx, any_valid out), first set bit at or after start wins
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any_valid
);
  logic [IW-1:0] k;
  always_comb begin
    idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(start) + i) % N);
      if (req[k]) idx = k;
    end
  end
  assign any_valid = |req;
  assign onehot = any_valid ? N'(1) << idx : '0;
endmodule

// File: rtl/sseg_display_arbiter.sv
// sseg_display_arbiter: round-robin owner of a 4-digit display (clk, clear, req, data_in -> grant, display_data, busy); SSEG_ARB_GAP_EN adds 2-cycle blank on handover
module sseg_display_arbiter
  import sseg_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int HOLD_CYCLES = 1000,
  parameter logic [15:0] IDLE_DATA = DEF_IDLE_DATA
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0][15:0] data_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [15:0]              display_data,
  output logic                     busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n, win_oh, take_oh;
  logic [15:0] data_n;
  logic [IW-1:0] last, last_n, start, win_idx, take_idx;
  logic [HW-1:0] hcnt, hcnt_n, hinc;
  logic any, take;
`ifdef SSEG_ARB_GAP_EN
  logic gcnt, gcnt_n;
  logic [IW-1:0] pend, pend_n;
`endif
  assign start = (last == IW'(NUM_REQ - 1)) ? '0 : last + 1'b1;
  assign hinc = (hcnt == HW'(HOLD_CYCLES)) ? hcnt : hcnt + 1'b1;
  assign busy = |grant;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req & ~grant),
    .start(start),
    .onehot(win_oh),
    .idx(win_idx),
    .any_valid(any)
  );
  always_comb begin
    state_n = state;
    grant_n = grant;
    data_n = display_data;
    last_n = last;
    hcnt_n = hcnt;
    take = 1'b0;
    take_idx = win_idx;
    take_oh = win_oh;
`ifdef SSEG_ARB_GAP_EN
    gcnt_n = gcnt;
    pend_n = pend;
`endif
    case (state)
      IDLE: take = any;
      OWN: begin
        hcnt_n = hinc;
        data_n = data_in[last];
        if (any && (!req[last] || hinc == HW'(HOLD_CYCLES))) begin
`ifdef SSEG_ARB_GAP_EN
          state_n = GAP;
          grant_n = '0;
          data_n = IDLE_DATA;
          gcnt_n = 1'b0;
          pend_n = win_idx;
`else
          take = 1'b1;
`endif
        end else if (!req[last]) begin
          state_n = IDLE;
          grant_n = '0;
          data_n = IDLE_DATA;
        end
      end
`ifdef SSEG_ARB_GAP_EN
      GAP: begin
        gcnt_n = 1'b1;
        take = gcnt;
        take_idx = pend;
        take_oh = NUM_REQ'(1) << pend;
      end
`endif
      default: state_n = IDLE;
    endcase
    if (take) begin
      state_n = OWN;
      grant_n = take_oh;
      data_n = data_in[take_idx];
      hcnt_n = '0;
      last_n = take_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      grant <= '0;
      display_data <= IDLE_DATA;
      hcnt <= '0;
      last <= IW'(NUM_REQ - 1);
`ifdef SSEG_ARB_GAP_EN
      gcnt <= 1'b0;
      pend <= '0;
`endif
    end else begin
      state <= state_n;
      grant <= grant_n;
      display_data <= data_n;
      hcnt <= hcnt_n;
      last <= last_n;
`ifdef SSEG_ARB_GAP_EN
      gcnt <= gcnt_n;
      pend <= pend_n;
`endif
    end
  end
endmodule
